// File: rtl/sd_bitstream_decimator.sv
// Second-order CIC (sinc^2) decimator for a 1-bit sigma-delta stream, one word per DECIM strobes.
// Latency: word appears 2 cycles after the last strobe of a frame; valid/ready out, newest word overwrites.
// Build option SD_DECIMATOR_BIPOLAR_EN: signed output (2*c2 - DECIM^2); default is unsigned {1'b0, c2}.
module sd_bitstream_decimator #(
  parameter int DECIM = 16,
  localparam int W = $clog2(DECIM*DECIM+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d_in,
  input  logic         d_in_en,
  output logic [W:0]   d_out,
  output logic         d_out_valid,
  input  logic         d_out_ready,
  output logic         overrun
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECIM-1);

  typedef enum logic {EMPTY, FULL} buf_state_t;

  logic [W-1:0] i1, i2, i2_d, c1_d;
  logic [W-1:0] c1, c2;
  logic [CW-1:0] cnt;
  logic          frame_done;
  logic [W:0]    word;
  buf_state_t    state, state_nxt;
  logic          overrun_nxt;

  // Integrators wrap modulo 2^W; the comb differences stay exact because the result fits in W bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1         <= '0;
      i2         <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= d_in_en && (cnt == LAST);
      if (d_in_en) begin
        i1  <= i1 + W'(d_in);
        i2  <= i2 + i1;
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

  assign c1 = i2 - i2_d;
  assign c2 = c1 - c1_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i2_d <= '0;
      c1_d <= '0;
    end else if (frame_done) begin
      i2_d <= i2;
      c1_d <= c1;
    end
  end

`ifdef SD_DECIMATOR_BIPOLAR_EN
  assign word = {c2, 1'b0} - (W+1)'(DECIM*DECIM);
`else
  assign word = {1'b0, c2};
`endif

  always_comb begin
    state_nxt   = state;
    overrun_nxt = 1'b0;
    case (state)
      EMPTY: begin
        if (frame_done) state_nxt = FULL;
      end
      FULL: begin
        if (frame_done) begin
          state_nxt   = FULL;
          overrun_nxt = !d_out_ready;
        end else if (d_out_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      d_out   <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= overrun_nxt;
      if (frame_done) d_out <= word;
    end
  end

  assign d_out_valid = (state == FULL);

endmodule

// File: tb/tb_sd_bitstream_decimator.sv
// Directed bench for sd_bitstream_decimator: DECIM=16 instance for function/handshake/reset, DECIM=1024 for range.
module tb_sd_bitstream_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        d_in = 1'b0, d_in_en = 1'b0, d_out_ready = 1'b1;
  logic [9:0]  d_out;
  logic        d_out_valid, overrun;
  logic        d2_in = 1'b0, d2_in_en = 1'b0, d2_out_ready = 1'b1;
  logic [21:0] d2_out;
  logic        d2_out_valid, d2_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int ph       = 0;

  always #5 clk = ~clk;

  sd_bitstream_decimator #(.DECIM(16)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .d_in_en(d_in_en),
    .d_out(d_out), .d_out_valid(d_out_valid), .d_out_ready(d_out_ready), .overrun(overrun)
  );

  sd_bitstream_decimator #(.DECIM(1024)) dut_big (
    .clk(clk), .rst(rst), .d_in(d2_in), .d_in_en(d2_in_en),
    .d_out(d2_out), .d_out_valid(d2_out_valid), .d_out_ready(d2_out_ready), .overrun(d2_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected output word from the hand-computed unsigned comb result c2.
  function automatic logic [9:0] exp16(input int c2);
`ifdef SD_DECIMATOR_BIPOLAR_EN
    return 10'(2*c2 - 256);
`else
    return 10'(c2);
`endif
  endfunction

  function automatic logic [21:0] exp1024(input int c2);
`ifdef SD_DECIMATOR_BIPOLAR_EN
    return 22'(2*c2 - 1048576);
`else
    return 22'(c2);
`endif
  endfunction

  task automatic tick(input logic en, input logic d);
    d_in_en = en;
    d_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    d_in_en     = 1'b0;
    d_in        = 1'b0;
    d_out_ready = 1'b1;
    d2_in_en    = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    ph = 0;
  endtask

  // Strobe every 'period' cycles with d_in=1 until a valid word shows up; n = cycles taken.
  task automatic wait_word(input string tag, input int period, input int budget,
                           output int n, output logic [9:0] v);
    logic found;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      tick((ph % period) == 0, 1'b1);
      ph++;
      n++;
      if (d_out_valid) found = 1'b1;
    end
    v = d_out;
    check({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  int          n, idle_valid, ovr, w;
  logic [9:0]  v;
  int          s2_exp[7] = '{64, 128, 128, 64, 0, 120, 256};

  initial begin
    // reset state
    do_reset();
    check("rst_dout", 32'(d_out), 32'd0);
    check("rst_valid", 32'(d_out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // constant ones, strobe every cycle
    wait_word("s1w1", 1, 40, n, v);
    check("s1w1_lat", 32'(n), 32'd17);
    check("s1w1_val", 32'(v), 32'(exp16(120)));
    wait_word("s1w2", 1, 40, n, v);
    check("s1w2_gap", 32'(n), 32'd16);
    check("s1w2_val", 32'(v), 32'(exp16(256)));
    wait_word("s1w3", 1, 40, n, v);
    check("s1w3_gap", 32'(n), 32'd16);
    check("s1w3_val", 32'(v), 32'(exp16(256)));

    // alternating 1010 for 3 frames, zeros for 2, then ones
    do_reset();
    for (int t = 1; t <= 113; t++) begin
      tick(1'b1, (t <= 48) ? logic'(t % 2) : ((t <= 80) ? 1'b0 : 1'b1));
      if (t > 1 && (t % 16) == 1) begin
        check($sformatf("s2_valid_t%0d", t), 32'(d_out_valid), 32'd1);
        check($sformatf("s2_val_t%0d", t), 32'(d_out), 32'(exp16(s2_exp[t/16 - 1])));
      end
    end

    // strobe every 3rd cycle, then a long idle gap
    do_reset();
    wait_word("s3w1", 3, 80, n, v);
    check("s3w1_lat", 32'(n), 32'd47);
    check("s3w1_val", 32'(v), 32'(exp16(120)));
    wait_word("s3w2", 3, 80, n, v);
    check("s3w2_gap", 32'(n), 32'd48);
    check("s3w2_val", 32'(v), 32'(exp16(256)));
    idle_valid = 0;
    repeat (100) begin
      tick(1'b0, 1'b1);
      if (d_out_valid) idle_valid++;
    end
    check("s3_idle_words", 32'(idle_valid), 32'd0);
    wait_word("s3w3", 1, 40, n, v);
    check("s3w3_val", 32'(v), 32'(exp16(256)));

    // consumer stalled: overwrite behaviour and same-cycle ready
    do_reset();
    d_out_ready = 1'b0;
    ovr = 0;
    for (int t = 1; t <= 66; t++) begin
      if (t == 65) d_out_ready = 1'b1;
      tick(1'b1, 1'b1);
      if (overrun) ovr++;
      if (t == 17) begin
        check("s4_t17_valid", 32'(d_out_valid), 32'd1);
        check("s4_t17_val", 32'(d_out), 32'(exp16(120)));
        check("s4_t17_ovr", 32'(overrun), 32'd0);
      end
      if (t == 32) begin
        check("s4_t32_valid", 32'(d_out_valid), 32'd1);
        check("s4_t32_stable", 32'(d_out), 32'(exp16(120)));
      end
      if (t == 33) begin
        check("s4_t33_val", 32'(d_out), 32'(exp16(256)));
        check("s4_t33_ovr", 32'(overrun), 32'd1);
      end
      if (t == 34) check("s4_t34_ovr", 32'(overrun), 32'd0);
      if (t == 49) check("s4_t49_ovr", 32'(overrun), 32'd1);
      if (t == 65) begin
        check("s4_t65_ovr", 32'(overrun), 32'd0);
        check("s4_t65_valid", 32'(d_out_valid), 32'd1);
      end
      if (t == 66) check("s4_t66_valid", 32'(d_out_valid), 32'd0);
    end
    check("s4_ovr_count", 32'(ovr), 32'd2);

    // asynchronous reset at strobe 7 of the second frame
    do_reset();
    d_out_ready = 1'b0;
    repeat (23) tick(1'b1, 1'b1);
    check("s5_pre_valid", 32'(d_out_valid), 32'd1);
    check("s5_pre_val", 32'(d_out), 32'(exp16(120)));
    #2 rst = 1'b0;
    #1;
    check("s5_rst_dout", 32'(d_out), 32'd0);
    check("s5_rst_valid", 32'(d_out_valid), 32'd0);
    check("s5_rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    d_out_ready = 1'b1;
    ph = 0;
    wait_word("s5w1", 1, 40, n, v);
    check("s5w1_lat", 32'(n), 32'd17);
    check("s5w1_val", 32'(v), 32'(exp16(120)));

    // DECIM=1024, constant ones for four frames
    do_reset();
    d2_in       = 1'b1;
    d2_in_en    = 1'b1;
    d2_out_ready = 1'b1;
    w = 0;
    for (int c = 0; c < 4200 && w < 4; c++) begin
      @(posedge clk);
      #1;
      if (d2_out_valid) begin
        check($sformatf("s6_word%0d", w + 1), 32'(d2_out),
              32'(exp1024((w == 0) ? 523776 : 1048576)));
        w++;
      end
    end
    check("s6_word_count", 32'(w), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
